// File: rtl/s1c88_bus_arbiter_if.sv
// s1c88_bus_arbiter_if: request/response handshake of one bus master
interface s1c88_bus_arbiter_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/s1c88_bus_arbiter.sv
// s1c88_bus_arbiter: shares the memory bus between the CPU (m0) and the PRC/DMA engine (m1)
module s1c88_bus_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 8,
   parameter int MEM_LATENCY = 2,
   parameter int MAX_CONSEC  = 4
) (
   input  logic                clk,
   input  logic                reset,
   s1c88_bus_arbiter_if.slave  m0,
   s1c88_bus_arbiter_if.slave  m1,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_read,
   output logic                mem_write,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                owner
);
   typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACK} state_t;
   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        consec_q, consec_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              busy_q, busy_d;
   logic              grant1;
   // next-state: arbitrate in IDLE, strobe in ADDR, count down the memory latency, pulse ack
   always_comb begin
      grant1   = m1.req && (!m0.req || consec_q < 4'(MAX_CONSEC));
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      consec_d = consec_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: if (m0.req || m1.req) begin
            state_d  = ADDR;
            owner_d  = grant1;
            we_d     = grant1 ? m1.we : m0.we;
            addr_d   = grant1 ? m1.addr : m0.addr;
            wdata_d  = grant1 ? m1.wdata : m0.wdata;
            rd_d     = !we_d;
            wr_d     = we_d;
            busy_d   = 1'b1;
            consec_d = !grant1 ? 4'd0 :
                       (m0.req && consec_q < 4'(MAX_CONSEC)) ? consec_q + 4'd1 : consec_q;
         end
         ADDR: begin
            state_d = WAIT;
            cnt_d   = 4'(MEM_LATENCY);
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d  = ACK;
               ack0_d   = !owner_q;
               ack1_d   = owner_q;
               rdata0_d = (!we_q && !owner_q) ? mem_rdata : rdata0_q;
               rdata1_d = (!we_q && owner_q) ? mem_rdata : rdata1_q;
            end
         end
         ACK: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end
   // state and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         cnt_q    <= 4'd0;
         consec_q <= 4'd0;
         addr_q   <= '1;
         wdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         consec_q <= consec_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
      end
   end
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_read  = rd_q;
   assign mem_write = wr_q;
   assign m0.ack    = ack0_q;
   assign m1.ack    = ack1_q;
   assign m0.rdata  = rdata0_q;
   assign m1.rdata  = rdata1_q;
   assign busy      = busy_q;
   assign owner     = owner_q;
endmodule

// File: tb/tb_s1c88_bus_arbiter.sv
// tb_s1c88_bus_arbiter: directed checks of arbitration, strobe/ack timing and reset
module tb_s1c88_bus_arbiter;
   localparam int LAT = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int fails = 0;
   logic [7:0] exp_r0 = 8'h00;
   logic [7:0] exp_r1 = 8'h00;
   always #5 clk = ~clk;

   s1c88_bus_arbiter_if #(.ADDR_W(24), .DATA_W(8)) m0 ();
   s1c88_bus_arbiter_if #(.ADDR_W(24), .DATA_W(8)) m1 ();
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy, owner;

   s1c88_bus_arbiter #(.ADDR_W(24), .DATA_W(8), .MEM_LATENCY(LAT), .MAX_CONSEC(4)) dut (
      .clk(clk), .reset(reset), .m0(m0), .m1(m1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

   s1c88_bus_arbiter_if #(.ADDR_W(24), .DATA_W(8)) n0 ();
   s1c88_bus_arbiter_if #(.ADDR_W(24), .DATA_W(8)) n1 ();
   logic [23:0] b_mem_addr;
   logic [7:0]  b_mem_wdata, b_mem_rdata;
   logic        b_mem_read, b_mem_write, b_busy, b_owner;

   s1c88_bus_arbiter #(.ADDR_W(24), .DATA_W(8), .MEM_LATENCY(1), .MAX_CONSEC(4)) dut_b (
      .clk(clk), .reset(reset), .m0(n0), .m1(n1),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
      .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rd"}, mem_read, 0);
      chk({tag, "_wr"}, mem_write, 0);
      chk({tag, "_ack0"}, m0.ack, 0);
      chk({tag, "_ack1"}, m1.ack, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // one transaction from master m with no competing request; cycle 0 = request cycle
   task automatic xact(input string tag, input bit m, input bit we, input logic [23:0] a,
                       input logic [7:0] wd, input logic [7:0] rd);
      @(negedge clk);
      if (m) begin
         m1.req = 1'b1; m1.we = we; m1.addr = a; m1.wdata = wd;
      end else begin
         m0.req = 1'b1; m0.we = we; m0.addr = a; m0.wdata = wd;
      end
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         mem_rdata = (k == LAT + 1) ? rd : ~rd;
         chk({tag, "_rd"}, mem_read, k == 1 && !we);
         chk({tag, "_wr"}, mem_write, k == 1 && we);
         chk({tag, "_ack0"}, m0.ack, k == LAT + 2 && !m);
         chk({tag, "_ack1"}, m1.ack, k == LAT + 2 && m);
         chk({tag, "_busy"}, busy, k <= LAT + 2);
         if (k == 1) begin
            chk({tag, "_addr"}, mem_addr, a);
            if (we) chk({tag, "_wdata"}, mem_wdata, wd);
         end
         if (k == LAT + 2) begin
            if (!we && !m) exp_r0 = rd;
            if (!we && m) exp_r1 = rd;
            chk({tag, "_rdata0"}, m0.rdata, exp_r0);
            chk({tag, "_rdata1"}, m1.rdata, exp_r1);
            chk({tag, "_owner"}, owner, m);
            m0.req = 1'b0;
            m1.req = 1'b0;
         end
      end
   endtask

   initial begin
      bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      int n_ack, n_strobe, last_strobe;
      m0.req = 0; m0.we = 0; m0.addr = 0; m0.wdata = 0;
      m1.req = 0; m1.we = 0; m1.addr = 0; m1.wdata = 0;
      n0.req = 0; n0.we = 0; n0.addr = 0; n0.wdata = 0;
      n1.req = 0; n1.we = 0; n1.addr = 0; n1.wdata = 0;
      mem_rdata = 0;
      b_mem_rdata = 0;
      // 1: reset with random inputs
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t1_addr", mem_addr, 24'hFFFFFF);
         chk("t1_wdata", mem_wdata, 0);
         chk("t1_rdata0", m0.rdata, 0);
         chk("t1_rdata1", m1.rdata, 0);
         chk("t1_owner", owner, 0);
         chk_idle("t1");
         m0.req = 1'($urandom); m0.we = 1'($urandom); m0.addr = 24'($urandom); m0.wdata = 8'($urandom);
         m1.req = 1'($urandom); m1.we = 1'($urandom); m1.addr = 24'($urandom); m1.wdata = 8'($urandom);
         mem_rdata = 8'($urandom);
      end
      m0.req = 0; m1.req = 0;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_idle("t1_post");
      end
      // 2: m0 read
      xact("t2", 0, 0, 24'h001234, 8'h00, 8'hA5);
      // 3: m1 write, m1 rdata must stay unchanged
      xact("t3", 1, 1, 24'h0F0000, 8'h3C, 8'hEE);
      // 4: both request reads continuously
      @(negedge clk);
      m0.req = 1; m0.we = 0; m0.addr = 24'h000100;
      m1.req = 1; m1.we = 0; m1.addr = 24'h000200;
      n_ack = 0; n_strobe = 0; last_strobe = 0;
      for (int k = 1; k <= 100 && n_ack < 10; k++) begin
         @(negedge clk);
         chk("t4_excl_strobe", mem_read & mem_write, 0);
         chk("t4_excl_ack", m0.ack & m1.ack, 0);
         if (mem_read) begin
            if (n_strobe > 0) chk("t4_spacing", k - last_strobe, LAT + 3);
            if (n_strobe < 10) chk("t4_addr", mem_addr, exp_order[n_strobe] ? 24'h000200 : 24'h000100);
            last_strobe = k;
            n_strobe++;
         end
         if (m0.ack || m1.ack) begin
            chk("t4_order", m1.ack, exp_order[n_ack]);
            n_ack++;
            if (n_ack == 10) begin
               m0.req = 0;
               m1.req = 0;
            end
         end
      end
      chk("t4_acks", n_ack, 10);
      @(negedge clk);
      chk_idle("t4_end");
      // 5: reset during WAIT abandons the transaction
      @(negedge clk);
      m0.req = 1; m0.we = 0; m0.addr = 24'h000040;
      @(negedge clk);
      chk("t5_strobe", mem_read, 1);
      @(negedge clk);
      reset = 1'b1;
      m0.req = 0;
      #1;
      chk_idle("t5_rst");
      chk("t5_addr", mem_addr, 24'hFFFFFF);
      exp_r0 = 8'h00;
      exp_r1 = 8'h00;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         mem_rdata = 8'h77;
         chk_idle("t5_hold");
      end
      reset = 1'b0;
      @(negedge clk);
      chk_idle("t5_rel");
      chk("t5_rdata0", m0.rdata, 0);
      xact("t5b", 0, 0, 24'h000010, 8'h00, 8'h96);
      // 6: MEM_LATENCY=1 instance
      @(negedge clk);
      n0.req = 1; n0.we = 0; n0.addr = 24'h000ABC;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         b_mem_rdata = (k == 2) ? 8'hC3 : 8'h3C;
         chk("t6_rd", b_mem_read, k == 1);
         chk("t6_ack0", n0.ack, k == 3);
         chk("t6_ack1", n1.ack, 0);
         if (k == 1) chk("t6_addr", b_mem_addr, 24'h000ABC);
         if (k == 3) begin
            chk("t6_rdata", n0.rdata, 8'hC3);
            n0.req = 0;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
